fp_to_int: RTL and testbench
============================

FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 SHALL have port clock100KHz, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1, request to convert op_in; sampled only in IDLE.
REQ-004 SHALL have port op_in, input, 32, float word: bit31 sign, bits30:25 biased exponent e, bits24:0 fraction m.
REQ-005 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-006 SHALL have port done, output, 1, single-cycle pulse, high exactly while in DONE.
REQ-007 SHALL have port data_out, output, 32, signed two's-complement integer result, held until the next DONE.
REQ-008 SHALL have port status_out, output, 4, one-hot: 0001 EXACT, 0010 INEXACT, 0100 OVERFLOW, 1000 UNDERFLOW; held with data_out.

Function
REQ-009 SHALL use bias 31: value = (-1)^s * 1.m * 2^(e-31); E = e-31; e=0 is zero/denormal class.
REQ-010 SHALL convert by truncation toward zero; INEXACT when any discarded fraction bit is 1, else EXACT.
REQ-011 SHALL implement states IDLE, CLASSIFY, SHIFT, SIGN, DONE; DONE always returns to IDLE next cycle.
REQ-012 IDLE with start=1 SHALL capture op_in into internal registers and go to CLASSIFY; start outside IDLE is ignored.
REQ-013 CLASSIFY special cases SHALL go directly to DONE with the result below:
  - e=0, m=0 (either sign) -> 0x00000000, EXACT.
  - e=0, m!=0 -> 0x00000000, UNDERFLOW.
  - 1<=e<=30 (|value|<1) -> 0x00000000, INEXACT.
  - e>=62, except s=1,e=62,m=0 -> saturate 0x7FFFFFFF (s=0) / 0x80000000 (s=1), OVERFLOW.
  - s=1, e=62, m=0 -> 0x80000000, EXACT.
REQ-014 Otherwise CLASSIFY SHALL load the 26-bit significand {1,m} into a 32-bit working register, clear sticky, set shift count n=|E-25| and direction (left if E>25, right if E<25); n=0 -> SIGN, else SHIFT.
REQ-015 SHIFT SHALL shift the working register one bit per cycle in the set direction, OR each bit shifted out on right shifts into sticky, decrement n, and go to SIGN on the cycle n goes 1->0.
REQ-016 SIGN SHALL negate the magnitude (two's complement) if s=1, and load data_out and status_out (INEXACT if sticky, else EXACT); then DONE.
REQ-017 Special-case results SHALL be loaded into data_out/status_out on the CLASSIFY->DONE edge.
REQ-018 Latency, from the edge sampling start to first cycle of done=1: 2 cycles for special cases, n+3 cycles otherwise (max 28 at e=31).
REQ-019 A new start SHALL be accepted in the IDLE cycle immediately following DONE (back-to-back throughput = latency+1).
REQ-020 op_in changes after capture SHALL not affect the conversion in progress.

Reset
REQ-021 reset=1 SHALL, at the next clock edge, force state IDLE, busy=0, done=0, data_out=0x00000000, status_out=0000, clear n and sticky.
REQ-022 reset SHALL take priority over start and over any in-progress state; the aborted conversion produces no done.

Verification
REQ-023 op_in=0x3E000000 (1.0), start pulse -> done after 28 cycles, data_out=0x00000001, status 0001.
REQ-024 op_in=0xC0800000 (-2.5) -> done after 27 cycles, data_out=0xFFFFFFFE, status 0010.
REQ-025 op_in=0x7A000000 (2^30) -> done after 8 cycles, data_out=0x40000000, status 0001; op_in=0x7C000000 -> done after 2, 0x7FFFFFFF, 0100; op_in=0xFC000000 -> 0x80000000, 0001.
REQ-026 op_in=0x00000001 -> done after 2, 0x00000000, 1000; op_in=0x3D000000 (0.75) -> done after 2, 0x00000000, 0010; op_in=0x80000000 -> 0x00000000, 0001.
REQ-027 Start 0x3E000000, assert reset during SHIFT cycle 10 -> no done, busy=0, data_out=0, status 0000; next start converts normally.
REQ-028 start held high continuously with alternating op_in -> each conversion uses the value captured in its IDLE cycle, done pulses one cycle each, one IDLE cycle between conversions.

Source files
------------

// File: rtl/fp_to_int.sv
// Multi-cycle converter from a bias-31 float word (6-bit exponent, 25-bit fraction)
// to a 32-bit signed integer. Truncates toward zero and shifts one bit per cycle.
module fp_to_int (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CLASSIFY = 3'd1;
    localparam logic [2:0] SHIFT    = 3'd2;
    localparam logic [2:0] SIGN     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam logic [3:0] ST_EXACT     = 4'b0001;
    localparam logic [3:0] ST_INEXACT   = 4'b0010;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
    localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

    // Exponent at which the significand's LSB has weight 1 (E = 25).
    localparam logic [5:0] EXP_UNIT = 6'd56;

    logic [2:0]  state;
    logic        sign_q;
    logic [5:0]  exp_q;
    logic [24:0] frac_q;
    logic [31:0] work;
    logic [4:0]  n;
    logic        shift_left;
    logic        sticky;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            state      <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= 6'd0;
            frac_q     <= 25'd0;
            work       <= 32'd0;
            n          <= 5'd0;
            shift_left <= 1'b0;
            sticky     <= 1'b0;
            data_out   <= 32'd0;
            status_out <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= op_in[31];
                        exp_q  <= op_in[30:25];
                        frac_q <= op_in[24:0];
                        state  <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    if (exp_q == 6'd0) begin
                        data_out   <= 32'd0;
                        status_out <= (frac_q == 25'd0) ? ST_EXACT : ST_UNDERFLOW;
                        state      <= DONE;
                    end else if (exp_q < 6'd31) begin
                        data_out   <= 32'd0;
                        status_out <= ST_INEXACT;
                        state      <= DONE;
                    end else if (exp_q >= 6'd62) begin
                        // -2^31 is the one magnitude at E=31 that still fits.
                        if (sign_q && exp_q == 6'd62 && frac_q == 25'd0) begin
                            data_out   <= 32'h8000_0000;
                            status_out <= ST_EXACT;
                        end else begin
                            data_out   <= sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                            status_out <= ST_OVERFLOW;
                        end
                        state <= DONE;
                    end else begin
                        work       <= {6'd0, 1'b1, frac_q};
                        sticky     <= 1'b0;
                        shift_left <= (exp_q > EXP_UNIT);
                        n          <= (exp_q > EXP_UNIT) ? 5'(exp_q - EXP_UNIT)
                                                         : 5'(EXP_UNIT - exp_q);
                        state      <= (exp_q == EXP_UNIT) ? SIGN : SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_left) begin
                        work <= work << 1;
                    end else begin
                        work   <= work >> 1;
                        sticky <= sticky | work[0];
                    end
                    n <= n - 5'd1;
                    if (n == 5'd1) state <= SIGN;
                end
                SIGN: begin
                    data_out   <= sign_q ? (~work + 32'd1) : work;
                    status_out <= sticky ? ST_INEXACT : ST_EXACT;
                    state      <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_to_int.sv
// Randomized and directed bench for fp_to_int against a value-level reference:
// the float is expanded to a wide integer, truncated, and range-checked.
module tb_fp_to_int;
    logic        clock100KHz = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int vecs = 0;
    int errs = 0;

    fp_to_int dut (
        .clock100KHz(clock100KHz),
        .reset(reset),
        .start(start),
        .op_in(op_in),
        .busy(busy),
        .done(done),
        .data_out(data_out),
        .status_out(status_out)
    );

    always #5 clock100KHz = ~clock100KHz;

    // Reference: exact value as a wide integer, truncated, then range-checked.
    function automatic void model(input logic [31:0] op, output logic [31:0] d,
                                  output logic [3:0] st, output int lat);
        longint sig;
        longint v;
        longint sv;
        longint mask;
        int     e;
        int     ex;
        bit     inex;
        e   = int'(op[30:25]);
        ex  = e - 31;
        sig = longint'({1'b1, op[24:0]});
        if (e == 0) begin
            d   = 32'd0;
            st  = (op[24:0] == 25'd0) ? 4'b0001 : 4'b1000;
            lat = 2;
            return;
        end
        if (ex >= 25) begin
            v    = sig << (ex - 25);
            inex = 1'b0;
        end else begin
            mask = (longint'(1) << (25 - ex)) - 1;
            v    = sig >> (25 - ex);
            inex = (sig & mask) != 0;
        end
        sv = op[31] ? -v : v;
        if (sv > 64'sd2147483647 || sv < -64'sd2147483648) begin
            d  = op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            st = 4'b0100;
        end else begin
            d  = sv[31:0];
            st = inex ? 4'b0010 : 4'b0001;
        end
        lat = (ex < 0 || ex >= 31) ? 2 : ((ex > 25) ? ex - 25 : 25 - ex) + 3;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [5:0]  e;
        logic [24:0] m;
        e = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(31, 61)) : 6'($urandom_range(0, 63));
        m = ($urandom_range(0, 4) == 0) ? 25'd0 : 25'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // Stimulus driver: one start pulse, optional noise on start/op_in while busy.
    task automatic run_conv(input logic [31:0] op, input bit noise, output int lat,
                            output logic [31:0] d, output logic [3:0] st, output bit got);
        op_in = op;
        start = 1'b1;
        @(posedge clock100KHz); #1;
        start = 1'b0;
        lat = 1;
        got = 1'b0;
        while (lat < 40) begin
            if (noise) begin
                op_in = $urandom;
                start = 1'($urandom_range(0, 1));
            end
            @(posedge clock100KHz); #1;
            lat++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        d  = data_out;
        st = status_out;
        @(posedge clock100KHz); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op_in = 32'd0;
        repeat (2) @(posedge clock100KHz);
        #1;
        vecs++;
        if ({busy, done, data_out, status_out} !== 38'd0) begin
            errs++;
            $display("FAIL reset_state: busy=%b done=%b data=%h status=%b, want all zero",
                     busy, done, data_out, status_out);
        end
        reset = 1'b0;
        @(posedge clock100KHz); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ops  [9] = '{32'h3E00_0000, 32'hC080_0000, 32'h7A00_0000, 32'h7C00_0000,
                                  32'hFC00_0000, 32'h0000_0001, 32'h3D00_0000, 32'h8000_0000,
                                  32'h3E00_0000};
        logic [31:0] xd   [9] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h4000_0000, 32'h7FFF_FFFF,
                                  32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                                  32'h0000_0001};
        logic [3:0]  xst  [9] = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001,
                                  4'b1000, 4'b0010, 4'b0001, 4'b0001};
        int          xlat [9] = '{28, 27, 8, 2, 2, 2, 2, 2, 28};
        int lat; logic [31:0] d; logic [3:0] st; bit got;
        for (int i = 0; i < 9; i++) begin
            run_conv(ops[i], 1'b0, lat, d, st, got);
            vecs++;
            if (!got || lat !== xlat[i] || d !== xd[i] || st !== xst[i]) begin
                errs++;
                $display("FAIL directed[%0d] op=%h: got=%0b lat=%0d data=%h status=%b, want lat=%0d data=%h status=%b",
                         i, ops[i], got, lat, d, st, xlat[i], xd[i], xst[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, xl; logic [31:0] d, xd, op; logic [3:0] st, xs; bit got;
        for (int i = 0; i < 300; i++) begin
            op = rand_op();
            model(op, xd, xs, xl);
            run_conv(op, 1'b1, lat, d, st, got);
            vecs++;
            if (!got || lat !== xl || d !== xd || st !== xs) begin
                errs++;
                $display("FAIL random[%0d] op=%h: got=%0b lat=%0d data=%h status=%b, want lat=%0d data=%h status=%b",
                         i, op, got, lat, d, st, xl, xd, xs);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] d; logic [3:0] st; bit got; bit seen;
        op_in = 32'h3E00_0000;
        start = 1'b1;
        @(posedge clock100KHz); #1;
        start = 1'b0;
        // One edge into SHIFT, then nine more: now in SHIFT cycle 10.
        repeat (10) @(posedge clock100KHz);
        #1;
        reset = 1'b1;
        @(posedge clock100KHz); #1;
        reset = 1'b0;
        vecs++;
        if ({busy, done, data_out, status_out} !== 38'd0) begin
            errs++;
            $display("FAIL reset_abort: busy=%b done=%b data=%h status=%b, want all zero",
                     busy, done, data_out, status_out);
        end
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clock100KHz); #1;
            if (done || busy) seen = 1'b1;
        end
        vecs++;
        if (seen) begin
            errs++;
            $display("FAIL reset_abort_quiet: busy/done=1 after abort, want 0");
        end
        run_conv(32'hC080_0000, 1'b0, lat, d, st, got);
        vecs++;
        if (!got || lat !== 27 || d !== 32'hFFFF_FFFE || st !== 4'b0010) begin
            errs++;
            $display("FAIL reset_recover: got=%0b lat=%0d data=%h status=%b, want lat=27 data=fffffffe status=0010",
                     got, lat, d, st);
        end
    endtask

    // start held high while op_in alternates every cycle.
    task automatic test_back_to_back();
        logic [31:0] a, b, cur, cap, xd; logic [3:0] xs; int xl, cyc; bit got;
        a = rand_op();
        b = rand_op();
        cur = a; op_in = cur; start = 1'b1;
        @(posedge clock100KHz); #1;
        cap = a;
        for (int k = 0; k < 6; k++) begin
            model(cap, xd, xs, xl);
            cyc = 1; got = 1'b0;
            while (cyc < 40) begin
                cur = (cur == a) ? b : a; op_in = cur;
                @(posedge clock100KHz); #1;
                cyc++;
                if (done) begin got = 1'b1; break; end
            end
            vecs++;
            if (!got || cyc !== xl || data_out !== xd || status_out !== xs) begin
                errs++;
                $display("FAIL b2b[%0d] cap=%h: got=%0b lat=%0d data=%h status=%b, want lat=%0d data=%h status=%b",
                         k, cap, got, cyc, data_out, status_out, xl, xd, xs);
            end
            cur = (cur == a) ? b : a; op_in = cur;
            @(posedge clock100KHz); #1;
            vecs++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errs++;
                $display("FAIL b2b_idle[%0d]: done=%b busy=%b, want 0 0", k, done, busy);
            end
            cur = (cur == a) ? b : a; op_in = cur; cap = cur;
            @(posedge clock100KHz); #1;
            vecs++;
            if (busy !== 1'b1) begin
                errs++;
                $display("FAIL b2b_accept[%0d]: busy=%b, want 1", k, busy);
            end
        end
        start = 1'b0;
        repeat (40) @(posedge clock100KHz);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
